// File: rtl/shift_rows_serial.sv
// shift_rows_serial: byte-serial AES ShiftRows using two ping-pong 16-byte buffers.
// Define SHIFT_ROWS_INV_EN to add the inv port, which selects InvShiftRows per block.
module shift_rows_serial (
    input  logic       clk,
    input  logic       rst_n,
`ifdef SHIFT_ROWS_INV_EN
    input  logic       inv,
`endif
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_last
);

    logic [7:0] buf_mem [2][16];
    logic [1:0] full;
    logic       wsel;
    logic       rsel;
    logic [3:0] wcnt;
    logic [3:0] rcnt;
    logic       mode_rd;
    logic       in_fire;
    logic       out_fire;

    // Output byte j = 4c+r reads buffer byte 4*col+r; col = c+r (fwd) or c-r (inv), mod 4.
    function automatic logic [3:0] src_idx(input logic [3:0] j, input logic inverse);
        logic [1:0] r;
        logic [1:0] c;
        logic [1:0] col;
        r   = j[1:0];
        c   = j[3:2];
        col = inverse ? (c - r) : (c + r);
        return {col, r};
    endfunction

    assign in_ready  = !full[wsel];
    assign out_valid = full[rsel];
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign out_data  = buf_mem[rsel][src_idx(rcnt, mode_rd)];
    assign out_last  = out_valid && (rcnt == 4'hf);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full <= 2'b00;
            wsel <= 1'b0;
            rsel <= 1'b0;
            wcnt <= 4'h0;
            rcnt <= 4'h0;
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < 16; i++) begin
                    buf_mem[b][i] <= 8'h00;
                end
            end
        end else begin
            // The full flags keep the write and read buffers distinct in any cycle.
            if (in_fire) begin
                buf_mem[wsel][wcnt] <= in_data;
                wcnt                <= wcnt + 4'd1;
                if (wcnt == 4'hf) begin
                    full[wsel] <= 1'b1;
                    wsel       <= ~wsel;
                end
            end
            if (out_fire) begin
                rcnt <= rcnt + 4'd1;
                if (rcnt == 4'hf) begin
                    full[rsel] <= 1'b0;
                    rsel       <= ~rsel;
                end
            end
        end
    end

`ifdef SHIFT_ROWS_INV_EN
    logic [1:0] mode;

    // Mapping mode is latched with byte 0 so later inv changes cannot affect the block.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode <= 2'b00;
        end else if (in_fire && (wcnt == 4'h0)) begin
            mode[wsel] <= inv;
        end
    end

    assign mode_rd = mode[rsel];
`else
    assign mode_rd = 1'b0;
`endif

endmodule

// File: tb/tb_shift_rows_serial.sv
// tb_shift_rows_serial: directed and randomized checks of the byte-serial ShiftRows engine.
// Inputs change 1 time unit after posedge; handshakes and outputs are observed at negedge.
module tb_shift_rows_serial;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_last;
`ifdef SHIFT_ROWS_INV_EN
    logic       inv_sig;
`endif

    shift_rows_serial dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef SHIFT_ROWS_INV_EN
        .inv       (inv_sig),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    int         cyc = 0;
    logic [7:0] out_q[$];
    logic       last_q[$];
    int         out_cyc[$];
    int         in_cyc[$];
    int         ready_drops = 0;
    int         stab_bad = 0;
    logic       prev_stall = 1'b0;
    logic [8:0] prev_word = '0;

    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            if (in_valid && in_ready) in_cyc.push_back(cyc);
            if (out_valid && out_ready) begin
                out_q.push_back(out_data);
                last_q.push_back(out_last);
                out_cyc.push_back(cyc);
            end
            if (in_valid && !in_ready) ready_drops++;
            if (prev_stall && out_valid && ({out_data, out_last} != prev_word)) stab_bad++;
            prev_stall = out_valid && !out_ready;
            prev_word  = {out_data, out_last};
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] ref_shift(input logic [127:0] s, input bit inverse);
        logic [127:0] o;
        int r;
        int c;
        int sc;
        o = '0;
        for (int j = 0; j < 16; j++) begin
            r  = j % 4;
            c  = j / 4;
            sc = inverse ? ((c - r + 4) % 4) : ((c + r) % 4);
            o[127 - 8 * j -: 8] = s[127 - 8 * (4 * sc + r) -: 8];
        end
        return o;
    endfunction

    task automatic clear_obs();
        out_q.delete();
        last_q.delete();
        out_cyc.delete();
        in_cyc.delete();
        ready_drops = 0;
        stab_bad    = 0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int g;
        g        = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && g < 2000) begin
            @(posedge clk);
            #1;
            g++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL in_timeout: got in_ready=0 after %0d cycles, required 1", g);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_block(input logic [127:0] blk, input bit gaps);
        for (int i = 0; i < 16; i++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            send_byte(blk[127 - 8 * i -: 8]);
        end
    endtask

    task automatic wait_out(input int n, input int budget);
        int g;
        g = 0;
        while (out_q.size() < n && g < budget) begin
            @(posedge clk);
            #1;
            g++;
        end
        if (out_q.size() < n) begin
            n_cmp++;
            n_bad++;
            $display("FAIL out_timeout: got %0d output bytes, required %0d", out_q.size(), n);
        end
    endtask

    task automatic pop_block(output logic [127:0] blk, output logic [15:0] lm);
        blk = '0;
        lm  = '0;
        for (int i = 0; i < 16; i++) begin
            if (out_q.size() > 0) begin
                blk[127 - 8 * i -: 8] = out_q.pop_front();
                lm[15 - i]            = last_q.pop_front();
            end
        end
    endtask

    typedef struct {
        logic [127:0] din;
        logic [127:0] dout;
    } vec_t;

    vec_t         vecs[3];
    logic [127:0] blk_a, blk_b, blk_c, got;
    logic [15:0]  lm;
    logic [127:0] exp_q[$];

    initial begin
        vecs[0] = '{128'hd42711aee0bf98f1b8b45de51e415230, 128'hd4bf5d30e0b452aeb84111f11e2798e5};
        vecs[1] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h00050a0f04090e03080d02070c01060b};
        vecs[2] = '{128'h00102030405060708090a0b0c0d0e0f0, 128'h0050a0f04090e03080d02070c01060b0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
`ifdef SHIFT_ROWS_INV_EN
        inv_sig   = 1'b0;
`endif

        // Reset values, both while held and just after release
        @(posedge clk);
        #1;
        check("rst_hold_flags", {125'd0, in_ready, out_valid, out_last}, {125'd0, 3'b100});
        check("rst_hold_data", {120'd0, out_data}, 128'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_after_flags", {125'd0, in_ready, out_valid, out_last}, {125'd0, 3'b100});
        check("rst_after_data", {120'd0, out_data}, 128'd0);

        // Table vectors, back-to-back with no backpressure
        clear_obs();
        out_ready = 1'b1;
        for (int v = 0; v < 3; v++) send_block(vecs[v].din, 1'b0);
        in_valid = 1'b0;
        wait_out(48, 200);
        if (in_cyc.size() >= 16 && out_cyc.size() >= 48) begin
            check("latency", 128'(out_cyc[0]), 128'(in_cyc[15] + 1));
            check("no_bubble", 128'(out_cyc[47] - out_cyc[0]), 128'd47);
        end
        check("in_ready_held", 128'(ready_drops), 128'd0);
        for (int v = 0; v < 3; v++) begin
            pop_block(got, lm);
            check($sformatf("vec%0d_data", v), got, vecs[v].dout);
            check($sformatf("vec%0d_last", v), {112'd0, lm}, 128'h0001);
        end

        // Backpressure: 32 bytes accepted, then in_ready drops and data holds
        clear_obs();
        out_ready = 1'b0;
        blk_a = {$urandom, $urandom, $urandom, $urandom};
        blk_b = {$urandom, $urandom, $urandom, $urandom};
        blk_c = {$urandom, $urandom, $urandom, $urandom};
        send_block(blk_a, 1'b0);
        send_block(blk_b, 1'b0);
        in_data  = blk_c[127:120];
        in_valid = 1'b1;
        repeat (6) begin
            @(posedge clk);
            #1;
        end
        check("bp_accepted", 128'(in_cyc.size()), 128'd32);
        check("bp_flags", {125'd0, in_ready, out_valid, out_last}, {125'd0, 3'b010});
        check("bp_head_byte", {120'd0, out_data}, {120'd0, ref_shift(blk_a, 1'b0)[127:120]});
        fork
            send_block(blk_c, 1'b0);
            out_ready = 1'b1;
        join
        in_valid = 1'b0;
        wait_out(48, 200);
        if (in_cyc.size() >= 33 && out_cyc.size() >= 16)
            check("bp_reassert", 128'(in_cyc[32]), 128'(out_cyc[15] + 1));
        check("bp_stable", 128'(stab_bad), 128'd0);
        pop_block(got, lm);
        check("bp_blk_a", got, ref_shift(blk_a, 1'b0));
        pop_block(got, lm);
        check("bp_blk_b", got, ref_shift(blk_b, 1'b0));
        pop_block(got, lm);
        check("bp_blk_c", got, ref_shift(blk_c, 1'b0));
        check("bp_last_c", {112'd0, lm}, 128'h0001);

        // Reset after 7 bytes of a partial block
        clear_obs();
        for (int i = 0; i < 7; i++) send_byte(8'hA0 + 8'(i));
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("midrst_flags", {125'd0, in_ready, out_valid, out_last}, {125'd0, 3'b100});
        clear_obs();
        send_block(vecs[1].din, 1'b0);
        in_valid = 1'b0;
        wait_out(16, 100);
        pop_block(got, lm);
        check("midrst_block", got, vecs[1].dout);
        check("midrst_last", {112'd0, lm}, 128'h0001);

        // 100 random blocks with random in_valid gaps and out_ready toggling
        clear_obs();
        exp_q.delete();
        fork
            begin
                for (int b = 0; b < 100; b++) begin
                    blk_a = {$urandom, $urandom, $urandom, $urandom};
                    exp_q.push_back(ref_shift(blk_a, 1'b0));
                    send_block(blk_a, 1'b1);
                end
                in_valid = 1'b0;
            end
            begin
                for (int g = 0; g < 20000 && out_q.size() < 1600; g++) begin
                    out_ready = 1'($urandom_range(0, 1));
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        wait_out(1600, 100);
        check("rand_count", 128'(out_q.size()), 128'd1600);
        check("rand_stable", 128'(stab_bad), 128'd0);
        for (int b = 0; b < 100; b++) begin
            pop_block(got, lm);
            check($sformatf("rand_blk%0d", b), {got, lm}, {exp_q[b], 16'h0001});
        end
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("rand_extra", {127'd0, out_valid}, 128'd0);

`ifdef SHIFT_ROWS_INV_EN
        // Inverse block followed by forward block; inv toggled mid-block must not matter
        clear_obs();
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            inv_sig = (i == 0) ? 1'b1 : 1'(i % 2);
            send_byte(vecs[0].dout[127 - 8 * i -: 8]);
        end
        for (int i = 0; i < 16; i++) begin
            inv_sig = (i == 0) ? 1'b0 : 1'(i % 2);
            send_byte(vecs[1].din[127 - 8 * i -: 8]);
        end
        in_valid = 1'b0;
        wait_out(32, 100);
        pop_block(got, lm);
        check("inv_block", got, vecs[0].din);
        pop_block(got, lm);
        check("fwd_after_inv", got, vecs[1].dout);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
